// File: rtl/fifo_simple_if.sv
// Handshake and status bundle between a fifo_simple instance and its producer/consumer.
// The master side drives push/pop; the slave side is the FIFO itself.
interface fifo_simple_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  full_a;
    logic                  empty;
    logic                  empty_a;

    modport master (
        output push, push_data, pop,
        input  pop_data, count, full, full_a, empty, empty_a
    );

    modport slave (
        input  push, push_data, pop,
        output pop_data, count, full, full_a, empty, empty_a
    );
endinterface

// File: rtl/fifo_simple.sv
// Single-clock first-word-fall-through FIFO with exact fill count and status flags.
// Depth is 2^ADDR_WIDTH; flags decode the registered count.
module fifo_simple #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fifo_simple_if.slave  bus
);
    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_push_en;
    logic w_pop_en;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == CNT_W'(0));
    // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
    assign w_pop_en  = bus.pop && !w_empty;
    assign w_push_en = bus.push && (!w_full || w_pop_en);

    // Storage is not reset; a reset cycle simply blocks the write.
    always_ff @(posedge clk) begin
        if (rst && w_push_en) begin
            r_mem[r_wr_ptr] <= bus.push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.count    = r_count;
    assign bus.full     = w_full;
    assign bus.full_a   = (r_count >= CNT_W'(DEPTH / 2));
    assign bus.empty    = w_empty;
    assign bus.empty_a  = (r_count <= CNT_W'(1));
    assign bus.pop_data = r_mem[r_rd_ptr];
endmodule

// File: tb/tb_fifo_simple.sv
// Directed bench for fifo_simple: reset, overfill, drain, wrap, concurrent push/pop.
module tb_fifo_simple;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    fifo_simple_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_simple #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int n);
        return 32'hC0DE_0000 | DW'(n);
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input int cnt, input bit f, input bit fa,
                               input bit e, input bit ea);
        check_val({tag, ".count"},   64'(bus.count),   64'(cnt));
        check_val({tag, ".full"},    64'(bus.full),    64'(f));
        check_val({tag, ".full_a"},  64'(bus.full_a),  64'(fa));
        check_val({tag, ".empty"},   64'(bus.empty),   64'(e));
        check_val({tag, ".empty_a"}, 64'(bus.empty_a), 64'(ea));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.push_data = '0;

        // Reset held for 6 cycles, then released.
        repeat (6) tick();
        check_flags("reset", 0, 0, 0, 1, 1);
        rst = 1'b1;
        tick();
        check_flags("post_reset", 0, 0, 0, 1, 1);

        // Overfill: 20 pushes, only 16 accepted.
        for (int i = 1; i <= 20; i++) begin
            bus.push = 1'b1;
            bus.push_data = word(i);
            tick();
            check_val("fill.count", 64'(bus.count), 64'((i > 16) ? 16 : i));
            if (i == 1) begin
                check_val("fill.first_visible", 64'(bus.pop_data), 64'(word(1)));
                check_flags("fill.one", 1, 0, 0, 0, 1);
            end
            if (i == 7) check_val("fill.full_a_7", 64'(bus.full_a), 64'(0));
            if (i == 8) check_val("fill.full_a_8", 64'(bus.full_a), 64'(1));
        end
        bus.push = 1'b0;
        check_flags("fill.full", 16, 1, 1, 0, 0);

        // Drain 16, data in order.
        for (int i = 1; i <= 16; i++) begin
            check_val("drain.data", 64'(bus.pop_data), 64'(word(i)));
            bus.pop = 1'b1;
            tick();
            check_val("drain.count", 64'(bus.count), 64'(16 - i));
        end
        check_flags("drain.empty", 0, 0, 0, 1, 1);
        repeat (3) tick();
        bus.pop = 1'b0;
        check_val("drain.underflow", 64'(bus.count), 64'(0));

        // Partial fill, partial drain, then overfill across pointer wrap.
        for (int i = 0; i < 5; i++) begin
            bus.push = 1'b1;
            bus.push_data = word(101 + i);
            tick();
        end
        bus.push = 1'b0;
        check_val("part.count5", 64'(bus.count), 64'(5));
        check_val("part.full_a", 64'(bus.full_a), 64'(0));
        bus.pop = 1'b1;
        repeat (2) tick();
        bus.pop = 1'b0;
        check_val("part.count3", 64'(bus.count), 64'(3));
        check_val("part.head", 64'(bus.pop_data), 64'(word(103)));
        for (int i = 0; i < 15; i++) begin
            bus.push = 1'b1;
            bus.push_data = word(201 + i);
            tick();
        end
        bus.push = 1'b0;
        check_flags("wrap.full", 16, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            check_val("wrap.data", 64'(bus.pop_data),
                      64'((i < 3) ? word(103 + i) : word(201 + i - 3)));
            bus.pop = 1'b1;
            tick();
        end
        bus.pop = 1'b0;
        check_flags("wrap.half", 8, 0, 1, 0, 0);

        // Concurrent push+pop at count 8; queue holds 206..213.
        for (int i = 0; i < 15; i++) begin
            check_val("both.data", 64'(bus.pop_data),
                      64'((i < 8) ? word(206 + i) : word(301 + i - 8)));
            bus.push = 1'b1;
            bus.pop = 1'b1;
            bus.push_data = word(301 + i);
            tick();
            check_val("both.count", 64'(bus.count), 64'(8));
        end
        bus.push = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_val("tail.data", 64'(bus.pop_data), 64'(word(308 + i)));
            tick();
            check_val("tail.count", 64'(bus.count), 64'(7 - i));
            check_val("tail.empty_a", 64'(bus.empty_a), 64'((7 - i) <= 1));
            check_val("tail.empty", 64'(bus.empty), 64'((7 - i) == 0));
        end
        bus.pop = 1'b0;

        // Push and pop together while empty: only the write happens.
        bus.push = 1'b1;
        bus.pop = 1'b1;
        bus.push_data = word(401);
        tick();
        bus.pop = 1'b0;
        bus.push = 1'b0;
        check_flags("empty_both", 1, 0, 0, 0, 1);
        check_val("empty_both.data", 64'(bus.pop_data), 64'(word(401)));

        // Fill to 16, then push+pop while full appends the new word.
        for (int i = 0; i < 15; i++) begin
            bus.push = 1'b1;
            bus.push_data = word(402 + i);
            tick();
        end
        check_val("full_both.pre", 64'(bus.count), 64'(16));
        bus.pop = 1'b1;
        bus.push_data = word(417);
        tick();
        bus.push = 1'b0;
        check_val("full_both.count", 64'(bus.count), 64'(16));
        check_val("full_both.full", 64'(bus.full), 64'(1));
        for (int i = 0; i < 16; i++) begin
            check_val("full_both.data", 64'(bus.pop_data), 64'(word(402 + i)));
            tick();
        end
        bus.pop = 1'b0;
        check_flags("full_both.end", 0, 0, 0, 1, 1);

        // Reset overrides a concurrent push and discards contents.
        bus.push = 1'b1;
        bus.push_data = word(501);
        repeat (3) tick();
        check_val("rst_mid.pre", 64'(bus.count), 64'(3));
        rst = 1'b0;
        tick();
        check_flags("rst_mid", 0, 0, 0, 1, 1);
        bus.push = 1'b0;
        rst = 1'b1;
        tick();
        check_flags("rst_mid.after", 0, 0, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
